// File: rtl/crc_chk.sv
// Serial CRC checker: frames of DW-bit words are folded into a Galois LFSR one bit
// per clock, MSB first, and the result is compared with the CRC received alongside the last word.
module crc_chk #(
  parameter int            DW   = 8,
  parameter int            PW   = 8,
  parameter logic [PW-1:0] POLY = PW'(8'h07),
  parameter logic [PW-1:0] INIT = '0,
  parameter int            CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            clear,
  input  logic [DW-1:0]   din,
  input  logic            din_valid,
  input  logic            din_last,
  input  logic [PW-1:0]   crc_in,
  output logic            ready,
  output logic            done,
  output logic            pass,
  output logic [PW-1:0]   crc_out,
  output logic [CNTW-1:0] err_cnt
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_lfsr;
  logic [DW-1:0]   r_sr;
  logic [CW-1:0]   r_cnt;
  logic            r_last;
  logic [PW-1:0]   r_crc_q;
  logic            r_done;
  logic            r_pass;
  logic [PW-1:0]   r_crc_out;
  logic [CNTW-1:0] r_err_cnt;

  state_t          w_state_nx;
  logic [PW-1:0]   w_lfsr_nx;
  logic [DW-1:0]   w_sr_nx;
  logic [CW-1:0]   w_cnt_nx;
  logic            w_last_nx;
  logic [PW-1:0]   w_crc_q_nx;
  logic            w_done_nx;
  logic            w_pass_nx;
  logic [PW-1:0]   w_crc_out_nx;
  logic [CNTW-1:0] w_err_nx;
  logic            w_ready;
  logic            w_accept;
  logic            w_match;

  // One Galois LFSR step for a single message bit.
  function automatic logic [PW-1:0] f_crc_bit(input logic [PW-1:0] r, input logic b);
    logic fb;
    fb = r[PW-1] ^ b;
    return (r << 1) ^ (fb ? POLY : '0);
  endfunction

  function automatic logic [CNTW-1:0] f_sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  assign w_ready  = (r_state == S_IDLE) && !clear;
  assign w_accept = w_ready && din_valid;
  assign w_match  = (r_lfsr == r_crc_q);

  always_comb begin
    w_state_nx   = r_state;
    w_lfsr_nx    = r_lfsr;
    w_sr_nx      = r_sr;
    w_cnt_nx     = r_cnt;
    w_last_nx    = r_last;
    w_crc_q_nx   = r_crc_q;
    w_done_nx    = 1'b0;
    w_pass_nx    = r_pass;
    w_crc_out_nx = r_crc_out;
    w_err_nx     = r_err_cnt;
    if (clear) begin
      // Abort drops any frame in flight, including a result not yet published.
      w_state_nx = S_IDLE;
      w_lfsr_nx  = INIT;
      w_cnt_nx   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_sr_nx    = din;
            w_last_nx  = din_last;
            if (din_last) w_crc_q_nx = crc_in;
            w_cnt_nx   = CW'(DW);
            w_state_nx = S_SHIFT;
          end
        end
        S_SHIFT: begin
          w_lfsr_nx = f_crc_bit(r_lfsr, r_sr[DW-1]);
          w_sr_nx   = r_sr << 1;
          w_cnt_nx  = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_state_nx = r_last ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          w_done_nx    = 1'b1;
          w_pass_nx    = w_match;
          w_crc_out_nx = r_lfsr;
          if (!w_match) w_err_nx = f_sat_inc(r_err_cnt);
          w_lfsr_nx    = INIT;
          w_state_nx   = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_lfsr    <= INIT;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_crc_q   <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_crc_out <= '0;
      r_err_cnt <= '0;
    end else begin
      r_lfsr    <= w_lfsr_nx;
      r_sr      <= w_sr_nx;
      r_cnt     <= w_cnt_nx;
      r_last    <= w_last_nx;
      r_crc_q   <= w_crc_q_nx;
      r_done    <= w_done_nx;
      r_pass    <= w_pass_nx;
      r_crc_out <= w_crc_out_nx;
      r_err_cnt <= w_err_nx;
    end
  end

  assign ready   = w_ready;
  assign done    = r_done;
  assign pass    = r_pass;
  assign crc_out = r_crc_out;
  assign err_cnt = r_err_cnt;

endmodule
